// File: rtl/data_cache_if.sv
// Core-side load/store request bus of the data cache.
// The core drives the request as master; the cache answers with rdata and stall as slave.
interface data_cache_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  rdata, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output rdata, stall
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with zero-latency hits.
// A miss stalls the core while a dirty victim is written back and the line is refilled word by word.
module data_cache #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          reset,
  data_cache_if.slave   bus,
  output logic [31:0]   mem_address,
  output logic [31:0]   mem_wdata,
  output logic          mem_store,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int TW = 30 - IW - OW;
  localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t                  state, next_state;
  logic [OW-1:0]           cnt;
  logic                    replay;
  logic [NUM_LINES-1:0]    valid;
  logic [NUM_LINES-1:0]    dirty;
  logic [TW-1:0]           tags  [NUM_LINES];
  logic [31:0]             words [NUM_LINES*LINE_WORDS];

  logic [OW-1:0]           off;
  logic [IW-1:0]           idx;
  logic [TW-1:0]           req_tag;
  logic                    hit;
  logic                    last;
  logic                    miss;
  logic                    complete;
  logic                    unused_addr_bits;

  assign off              = bus.req_addr[OW+1:2];
  assign idx              = bus.req_addr[OW+IW+1:OW+2];
  assign req_tag          = bus.req_addr[31:OW+IW+2];
  assign unused_addr_bits = ^bus.req_addr[1:0];
  assign hit              = valid[idx] && (tags[idx] == req_tag);
  assign last             = (cnt == LAST);

  always_comb begin
    next_state  = state;
    bus.stall   = 1'b0;
    bus.rdata   = '0;
    mem_store   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    miss        = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (hit) begin
            complete = 1'b1;
            if (!bus.req_write)
              bus.rdata = words[{idx, off}];
          end else begin
            bus.stall  = 1'b1;
            miss       = 1'b1;
            next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        bus.stall   = 1'b1;
        mem_store   = 1'b1;
        mem_address = {tags[idx], idx, cnt, 2'b00};
        mem_wdata   = words[{idx, cnt}];
        if (last)
          next_state = REFILL;
      end
      REFILL: begin
        bus.stall   = 1'b1;
        mem_address = {req_tag, idx, cnt, 2'b00};
        if (last)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The replay flag marks the first IDLE completion after a fill so it is not counted as a hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      replay     <= 1'b0;
      valid      <= '0;
      dirty      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (miss) begin
            cnt        <= '0;
            miss_count <= miss_count + 32'd1;
          end else if (complete) begin
            replay <= 1'b0;
            if (bus.req_write)
              dirty[idx] <= 1'b1;
            if (!replay)
              hit_count <= hit_count + 32'd1;
          end
        end
        WRITEBACK: cnt <= last ? '0 : cnt + 1'b1;
        REFILL: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            replay     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL) begin
      words[{idx, cnt}] <= mem_rdata;
      if (last)
        tags[idx] <= req_tag;
    end else if (complete && bus.req_write) begin
      words[{idx, off}] <= bus.req_wdata;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: table of accesses checked through a scoreboard queue,
// plus hand-written sequences for reset during writeback and hit counter wrap.
module tb_data_cache;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_stalls;
    logic [31:0] wb_base;
    logic [31:0] fill_base;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_store;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  logic [31:0] mem [0:1023];
  int          store_events;

  int          errors = 0;
  int          checks = 0;
  vec_t        vecs [10];
  vec_t        exp_q [$];
  logic [31:0] log_addr [$];
  logic        log_store [$];
  int          obs_stalls;
  logic [31:0] obs_rdata;
  logic        timed_out;

  data_cache_if bus();

  data_cache #(.NUM_LINES(4), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_store  (mem_store),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_address[11:2]];

  // Memory model: preload, then commit stores on the rising edge like data_memory.
  initial begin
    store_events = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'hDEADBEEF;
    mem[64] = 32'hCAFEBABE;
    mem[65] = 32'h0000_0099;
    forever begin
      @(posedge clk);
      if (mem_store) begin
        mem[mem_address[11:2]] <= mem_wdata;
        store_events = store_events + 1;
      end
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rd, input int stalls, input logic [31:0] wb,
                                 input logic [31:0] fill, input logic [31:0] hits, input logic [31:0] misses);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = rd; v.exp_stalls = stalls;
    v.wb_base = wb; v.fill_base = fill; v.exp_hits = hits; v.exp_misses = misses;
    return v;
  endfunction

  // Drive one request at a falling edge, log memory traffic while stalled, return one edge after completion.
  task automatic applyStimulus(input vec_t v);
    int n;
    exp_q.push_back(v);
    log_addr.delete();
    log_store.delete();
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    #1;
    n = 0;
    while (bus.stall && n < 50) begin
      log_addr.push_back(mem_address);
      log_store.push_back(mem_store);
      n++;
      @(negedge clk);
      #1;
    end
    timed_out  = bus.stall;
    obs_stalls = n;
    obs_rdata  = bus.rdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic checkOutput(input int id);
    vec_t e;
    int   wb_len;
    if (exp_q.size() == 0) begin
      checkValue($sformatf("v%0d scoreboard_empty", id), 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    wb_len = (e.exp_stalls > 5) ? 4 : 0;
    checkValue($sformatf("v%0d timeout", id), {31'd0, timed_out}, 32'd0);
    checkValue($sformatf("v%0d stall_cycles", id), obs_stalls, e.exp_stalls);
    if (!e.wr) checkValue($sformatf("v%0d rdata", id), obs_rdata, e.exp_rdata);
    checkValue($sformatf("v%0d hit_count", id), hit_count, e.exp_hits);
    checkValue($sformatf("v%0d miss_count", id), miss_count, e.exp_misses);
    for (int k = 0; k < log_addr.size() && k < e.exp_stalls; k++) begin
      if (k == 0) begin
        checkValue($sformatf("v%0d store_c0", id), {31'd0, log_store[k]}, 32'd0);
      end else if (k <= wb_len) begin
        checkValue($sformatf("v%0d wb_addr_c%0d", id, k), log_addr[k], e.wb_base + 32'(4 * (k - 1)));
        checkValue($sformatf("v%0d wb_store_c%0d", id, k), {31'd0, log_store[k]}, 32'd1);
      end else begin
        checkValue($sformatf("v%0d fill_addr_c%0d", id, k), log_addr[k], e.fill_base + 32'(4 * (k - 1 - wb_len)));
        checkValue($sformatf("v%0d fill_store_c%0d", id, k), {31'd0, log_store[k]}, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //                wr    addr          wdata         rdata         st  wb_base       fill_base     hits   misses
    vecs[0] = mkVec(1'b0, 32'h0000_0000, 32'h0,        32'hDEADBEEF, 5, 32'h0,        32'h0000_0000, 32'd0, 32'd1);
    vecs[1] = mkVec(1'b0, 32'h0000_0004, 32'h0,        32'h1000_0001, 0, 32'h0,       32'h0,         32'd1, 32'd1);
    vecs[2] = mkVec(1'b1, 32'h0000_0100, 32'h12345678, 32'h0,        5, 32'h0,        32'h0000_0100, 32'd1, 32'd2);
    vecs[3] = mkVec(1'b0, 32'h0000_0100, 32'h0,        32'h12345678, 0, 32'h0,        32'h0,         32'd2, 32'd2);
    vecs[4] = mkVec(1'b0, 32'h0000_0000, 32'h0,        32'hDEADBEEF, 9, 32'h0000_0100, 32'h0000_0000, 32'd2, 32'd3);
    vecs[5] = mkVec(1'b1, 32'h0000_0108, 32'hA5A5A5A5, 32'h0,        0, 32'h0,        32'h0,         32'd1, 32'd1);
    vecs[6] = mkVec(1'b0, 32'h0000_0108, 32'h0,        32'hA5A5A5A5, 0, 32'h0,        32'h0,         32'd2, 32'd1);
    vecs[7] = mkVec(1'b0, 32'h0000_001C, 32'h0,        32'h1000_0007, 5, 32'h0,       32'h0000_0010, 32'd2, 32'd2);
    vecs[8] = mkVec(1'b0, 32'h0000_0014, 32'h0,        32'h1000_0005, 0, 32'h0,       32'h0,         32'd3, 32'd2);
    vecs[9] = mkVec(1'b0, 32'h0000_0008, 32'h0,        32'h1000_0002, 9, 32'h0000_0100, 32'h0000_0000, 32'd3, 32'd3);

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkValue("reset stall", {31'd0, bus.stall}, 32'd0);
    checkValue("reset mem_store", {31'd0, mem_store}, 32'd0);
    checkValue("reset hit_count", hit_count, 32'd0);
    checkValue("reset miss_count", miss_count, 32'd0);
    checkValue("reset rdata", bus.rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
      if (i == 3) begin
        checkValue("mem64 untouched", mem[64], 32'hCAFEBABE);
        checkValue("no stores yet", store_events, 32'd0);
      end
    end
    checkValue("wb mem64", mem[64], 32'h12345678);
    checkValue("wb mem65", mem[65], 32'h0000_0099);
    checkValue("wb mem66", mem[66], 32'h1000_0042);
    checkValue("wb mem67", mem[67], 32'h1000_0043);
    checkValue("wb store count", store_events, 32'd4);

    // Reset during the second writeback cycle of a dirty eviction.
    applyStimulus(mkVec(1'b1, 32'h0000_0100, 32'h55AA55AA, 32'h0, 5, 32'h0, 32'h0000_0100, 32'd2, 32'd4));
    checkOutput(100);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0000;
    #1;
    checkValue("evict miss stall", {31'd0, bus.stall}, 32'd1);
    @(negedge clk);
    checkValue("evict wb0 store", {31'd0, mem_store}, 32'd1);
    checkValue("evict wb0 addr", mem_address, 32'h0000_0100);
    @(negedge clk);
    checkValue("evict wb1 addr", mem_address, 32'h0000_0104);
    reset = 1'b0;
    #1;
    checkValue("rst mem_store", {31'd0, mem_store}, 32'd0);
    checkValue("rst hit_count", hit_count, 32'd0);
    checkValue("rst miss_count", miss_count, 32'd0);
    checkValue("rst mem64 committed", mem[64], 32'h55AA55AA);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkValue("rst store count", store_events, 32'd5);
    reset = 1'b1;
    applyStimulus(mkVec(1'b0, 32'h0000_0104, 32'h0, 32'h0000_0099, 5, 32'h0, 32'h0000_0100, 32'd0, 32'd1));
    checkOutput(101);

    for (int i = 5; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end
    checkValue("evict2 mem66", mem[66], 32'hA5A5A5A5);
    checkValue("evict2 mem64", mem[64], 32'h55AA55AA);

    // Hit counter wrap from all-ones.
    force dut.hit_count = 32'hFFFF_FFFF;
    #1;
    release dut.hit_count;
    @(negedge clk);
    applyStimulus(mkVec(1'b0, 32'h0000_0000, 32'h0, 32'hDEADBEEF, 0, 32'h0, 32'h0, 32'd0, 32'd3));
    checkOutput(102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
